// File: rtl/ov7670_capture_pkg.sv
// Shared image geometry, buffer widths, colour threshold and test-bar palette
// for the OV7670 capture path and the display side.
package ov7670_capture_pkg;

  localparam int c_img_cols     = 80;
  localparam int c_img_rows     = 60;
  localparam int c_nb_img_pxls  = 13;
  localparam int c_nb_buf_red   = 4;
  localparam int c_nb_buf_green = 4;
  localparam int c_nb_buf_blue  = 4;
  localparam int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue;

  localparam int c_img_pxls = c_img_cols * c_img_rows;
  localparam int c_cam_cols = 2 * c_img_cols;
  localparam int c_cam_rows = 2 * c_img_rows;

  localparam logic [3:0] c_thresh = 4'd8;

  typedef struct packed {
    logic       rgbmode;
    logic       testmode;
    logic [2:0] rgbfilter;
  } mode_t;

  // Vertical colour bars, 16 frame columns wide each.
  function automatic logic [c_nb_buf-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hF00;
      3'd2:    bar_color = 12'h0F0;
      3'd3:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ov7670_capture_color_proc.sv
// Combinational pixel formatter: RGB444/YUV packing, per-channel colour
// filter and colour-bar test pattern.
module color_proc
  import ov7670_capture_pkg::*;
(
  input  logic                i_mode_rgb,
  input  logic                i_mode_test,
  input  logic [2:0]          i_filter,
  input  logic [7:0]          i_byte1,
  input  logic [7:0]          i_byte2,
  input  logic [6:0]          i_col,
  output logic [c_nb_buf-1:0] o_pixel
);

  logic [c_nb_buf-1:0] w_raw;
  logic [2:0]          w_chan_ok;

  assign w_raw = {i_byte1[3:0], i_byte2};

  // Channel gi: 2 = R, 1 = G, 0 = B, matching the {R,G,B} filter bits.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign w_chan_ok[gi] = i_filter[gi] ? (w_raw[gi*4 +: 4] >= c_thresh)
                                          : (w_raw[gi*4 +: 4] <  c_thresh);
    end
  endgenerate

  always_comb begin
    o_pixel = '0;
    if (i_mode_test) begin
      o_pixel = bar_color(i_col[6:4]);
    end else if (!i_mode_rgb) begin
      o_pixel = {{(c_nb_buf-8){1'b0}}, i_byte1};
    end else if (i_filter == 3'b000 || (&w_chan_ok)) begin
      o_pixel = w_raw;
    end
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 pixel-bus capture: synchronises the camera bus into clk, decimates
// 160x120 by 2 and emits frame-buffer writes plus an end-of-frame pulse.
module ov7670_capture
  import ov7670_capture_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ov7670_pclk,
  input  logic                     ov7670_vsync,
  input  logic                     ov7670_href,
  input  logic [7:0]               ov7670_d,
  input  logic                     rgbmode,
  input  logic                     testmode,
  input  logic [2:0]               rgbfilter,
  output logic                     frame_we,
  output logic [c_nb_img_pxls-1:0] frame_addr,
  output logic [c_nb_buf-1:0]      frame_pixel,
  output logic                     frame_done
);

  localparam logic [1:0] ST_WAIT_VS = 2'd0;
  localparam logic [1:0] ST_VBLANK  = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  localparam logic [7:0]               c_col_lim  = 8'(c_cam_cols);
  localparam logic [7:0]               c_row_lim  = 8'(c_cam_rows);
  localparam logic [c_nb_img_pxls-1:0] c_addr_lim = c_nb_img_pxls'(c_img_pxls);

  logic [10:0]              r_sync1, r_sync2;
  logic                     r_pclk3, r_href3;
  logic [1:0]               r_state;
  mode_t                    r_mode;
  logic                     r_phase;
  logic [7:0]               r_byte1;
  logic [7:0]               r_col, r_row;
  logic [c_nb_img_pxls-1:0] r_wr_addr;
  logic                     r_wrote;
  logic                     r_we;
  logic [c_nb_img_pxls-1:0] r_addr;
  logic [c_nb_buf-1:0]      r_pixel;
  logic                     r_done;

  logic                w_pclk_rise, w_vsync, w_href, w_href_fall, w_take;
  logic [7:0]          w_d;
  logic [c_nb_buf-1:0] w_pixel;

  assign w_pclk_rise = r_sync2[10] & ~r_pclk3;
  assign w_vsync     = r_sync2[9];
  assign w_href      = r_sync2[8];
  assign w_d         = r_sync2[7:0];
  assign w_href_fall = r_href3 & ~w_href;

  // Second byte of an even/even pixel inside the camera window, buffer not full.
  assign w_take = (r_state == ST_ACTIVE) && !w_vsync && w_pclk_rise && w_href &&
                  r_phase && !r_col[0] && !r_row[0] &&
                  (r_col < c_col_lim) && (r_row < c_row_lim) &&
                  (r_wr_addr < c_addr_lim);

  color_proc u_color_proc (
    .i_mode_rgb  (r_mode.rgbmode),
    .i_mode_test (r_mode.testmode),
    .i_filter    (r_mode.rgbfilter),
    .i_byte1     (r_byte1),
    .i_byte2     (w_d),
    .i_col       (r_col[7:1]),
    .o_pixel     (w_pixel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_pclk3   <= 1'b0;
      r_href3   <= 1'b0;
      r_state   <= ST_WAIT_VS;
      r_mode    <= '0;
      r_phase   <= 1'b0;
      r_byte1   <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_wr_addr <= '0;
      r_wrote   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_pixel   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_sync1 <= {ov7670_pclk, ov7670_vsync, ov7670_href, ov7670_d};
      r_sync2 <= r_sync1;
      r_pclk3 <= r_sync2[10];
      r_href3 <= r_sync2[8];
      r_we    <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        ST_WAIT_VS: begin
          if (w_vsync) r_state <= ST_VBLANK;
        end
        ST_VBLANK: begin
          r_row     <= '0;
          r_col     <= '0;
          r_phase   <= 1'b0;
          r_wr_addr <= '0;
          r_wrote   <= 1'b0;
          if (!w_vsync) begin
            r_state          <= ST_ACTIVE;
            r_mode.rgbmode   <= rgbmode;
            r_mode.testmode  <= testmode;
            r_mode.rgbfilter <= rgbfilter;
          end
        end
        ST_ACTIVE: begin
          if (w_vsync) begin
            r_state <= ST_VBLANK;
            r_done  <= r_wrote;
            r_row   <= '0;
            r_col   <= '0;
            r_phase <= 1'b0;
          end else begin
            if (!w_href) r_phase <= 1'b0;
            if (w_href_fall) begin
              r_col <= '0;
              r_row <= sat_inc8(r_row);
            end
            if (w_pclk_rise && w_href) begin
              r_phase <= ~r_phase;
              if (!r_phase) r_byte1 <= w_d;
              else          r_col   <= sat_inc8(r_col);
            end
            if (w_take) begin
              r_we      <= 1'b1;
              r_addr    <= r_wr_addr;
              r_pixel   <= w_pixel;
              r_wr_addr <= r_wr_addr + 1'b1;
              r_wrote   <= 1'b1;
            end
          end
        end
        default: r_state <= ST_WAIT_VS;
      endcase
    end
  end

  assign frame_we    = r_we;
  assign frame_addr  = r_addr;
  assign frame_pixel = r_pixel;
  assign frame_done  = r_done;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: camera-bus driver, write scoreboard and a
// per-frame table of mode/byte vectors with hand-derived pixel results.
module tb_ov7670_capture;
  import ov7670_capture_pkg::*;

  typedef struct packed {
    logic [12:0] addr;
    logic [11:0] pix;
  } exp_t;

  typedef struct {
    logic       rgbmode;
    logic       testmode;
    logic [2:0] filt;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ov_pclk, ov_vsync, ov_href;
  logic [7:0]  ov_d;
  logic        rgbmode, testmode;
  logic [2:0]  rgbfilter;
  logic        frame_we, frame_done;
  logic [12:0] frame_addr;
  logic [11:0] frame_pixel;

  always #5 clk = ~clk;

  ov7670_capture dut (
    .clk          (clk),
    .rst          (rst),
    .ov7670_pclk  (ov_pclk),
    .ov7670_vsync (ov_vsync),
    .ov7670_href  (ov_href),
    .ov7670_d     (ov_d),
    .rgbmode      (rgbmode),
    .testmode     (testmode),
    .rgbfilter    (rgbfilter),
    .frame_we     (frame_we),
    .frame_addr   (frame_addr),
    .frame_pixel  (frame_pixel),
    .frame_done   (frame_done)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  int          done_base, wr_base;
  logic [12:0] last_addr = '0;
  exp_t        sb[$];
  int          m_row, m_col, m_addr;
  bit          m_cap;
  bit          cur_test;
  logic [11:0] cur_exp;
  logic [11:0] bars[5];
  vec_t        vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic prev_we   = 1'b0;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        done_cnt++;
        check("done_width", {31'd0, prev_done}, 32'd0);
      end
      if (frame_we) begin
        wr_cnt++;
        last_addr = frame_addr;
        check("we_width", {31'd0, prev_we}, 32'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write addr=%0d pixel=0x%h required=no write", frame_addr, frame_pixel);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(frame_addr), 32'(e.addr));
          check("wr_pixel", 32'(frame_pixel), 32'(e.pix));
        end
      end
      prev_we   = frame_we;
      prev_done = frame_done;
    end
  endtask

  // One byte per three clk cycles: data set with pclk low, pclk high for two.
  task automatic send_byte(input logic [7:0] b);
    ov_d    = b;
    ov_pclk = 1'b0;
    @(negedge clk);
    ov_pclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    send_byte(b1);
    if (m_cap && (m_row % 2 == 0) && (m_col % 2 == 0) && m_row < 120 && m_col < 160 && m_addr < 4800) begin
      e.addr = 13'(m_addr);
      e.pix  = cur_test ? bars[(m_col / 2) / 16] : cur_exp;
      sb.push_back(e);
      m_addr++;
    end
    send_byte(b2);
    m_col++;
  endtask

  task automatic send_line(input int npix, input logic [7:0] b1, input logic [7:0] b2);
    ov_href = 1'b1;
    for (int p = 0; p < npix; p++) send_pixel(b1, b2);
    ov_pclk = 1'b0;
    @(negedge clk);
    ov_href = 1'b0;
    m_row++;
    m_col = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_frame();
    ov_href  = 1'b0;
    ov_vsync = 1'b1;
    repeat (4) @(negedge clk);
    ov_vsync = 1'b0;
    repeat (4) @(negedge clk);
    m_row = 0; m_col = 0; m_addr = 0; m_cap = 1'b1;
    done_base = done_cnt;
    wr_base   = wr_cnt;
  endtask

  task automatic end_frame(input string name, input int exp_done, input int exp_writes);
    ov_href  = 1'b0;
    ov_vsync = 1'b1;
    repeat (8) @(negedge clk);
    check({name, "_done"}, 32'(done_cnt - done_base), 32'(exp_done));
    check({name, "_writes"}, 32'(wr_cnt - wr_base), 32'(exp_writes));
    check({name, "_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
    $display("frame %s: writes=%0d done=%0d", name, wr_cnt - wr_base, done_cnt - done_base);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bars[0] = 12'hFFF; bars[1] = 12'hF00; bars[2] = 12'h0F0; bars[3] = 12'h00F; bars[4] = 12'h000;
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 8'h0A, 8'h5C, 12'hA5C};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 8'h0A, 8'h00, 12'hA00};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 8'h0A, 8'h90, 12'h000};
    vecs[3]  = '{1'b0, 1'b0, 3'b000, 8'h7E, 8'h33, 12'h07E};
    vecs[4]  = '{1'b0, 1'b0, 3'b101, 8'h7E, 8'h33, 12'h07E};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 8'h03, 8'h90, 12'h390};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 8'h07, 8'h78, 12'h778};
    vecs[7]  = '{1'b1, 1'b0, 3'b001, 8'h07, 8'h77, 12'h000};
    vecs[8]  = '{1'b1, 1'b0, 3'b111, 8'hF8, 8'h88, 12'h888};
    vecs[9]  = '{1'b1, 1'b0, 3'b111, 8'h08, 8'h87, 12'h000};
    vecs[10] = '{1'b1, 1'b1, 3'b100, 8'h0A, 8'h90, 12'hFFF};

    rst = 1'b1; ov_pclk = 1'b0; ov_vsync = 1'b0; ov_href = 1'b0; ov_d = 8'h00;
    rgbmode = 1'b1; testmode = 1'b0; rgbfilter = 3'b000;
    cur_test = 1'b0; cur_exp = 12'hA5C; m_cap = 1'b0; m_row = 0; m_col = 0; m_addr = 0;
    fork
      monitor();
    join_none
    repeat (4) @(negedge clk);
    check("rst_we", {31'd0, frame_we}, 32'd0);
    check("rst_addr", 32'(frame_addr), 32'd0);
    check("rst_pixel", 32'(frame_pixel), 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // Camera already mid-frame (vsync low) when reset lifts: nothing written.
    wr_base = wr_cnt; done_base = done_cnt;
    for (int l = 0; l < 3; l++) send_line(4, 8'h0A, 8'h5C);
    check("midframe_nowrite", 32'(wr_cnt - wr_base), 32'd0);
    start_frame();
    send_line(2, 8'h0A, 8'h5C);
    end_frame("first_frame", 1, 1);

    // Write strobe lands exactly one clk after the second-byte edge detect.
    start_frame();
    ov_href = 1'b1;
    send_byte(8'h0A);
    e.addr = 13'd0; e.pix = 12'hA5C;
    sb.push_back(e);
    send_byte(8'h5C);
    check("we_lat_early", {31'd0, frame_we}, 32'd0);
    @(negedge clk);
    check("we_lat_on", {31'd0, frame_we}, 32'd1);
    check("we_lat_addr", 32'(frame_addr), 32'd0);
    @(negedge clk);
    check("we_lat_off", {31'd0, frame_we}, 32'd0);
    ov_pclk = 1'b0;
    @(negedge clk);
    ov_href = 1'b0;
    repeat (2) @(negedge clk);
    end_frame("latency", 1, 1);

    for (int i = 0; i < 11; i++) begin
      rgbmode = vecs[i].rgbmode; testmode = vecs[i].testmode; rgbfilter = vecs[i].filt;
      cur_exp = vecs[i].exp;
      start_frame();
      send_line(3, vecs[i].b1, vecs[i].b2);
      end_frame($sformatf("vec%0d", i), 1, 2);
    end

    // Modes changed mid-frame must not affect the frame in progress.
    rgbmode = 1'b1; testmode = 1'b0; rgbfilter = 3'b000; cur_exp = 12'hA5C;
    start_frame();
    rgbmode = 1'b0; testmode = 1'b1; rgbfilter = 3'b010;
    send_line(1, 8'h0A, 8'h5C);
    end_frame("mode_latch", 1, 1);

    rgbmode = 1'b1; testmode = 1'b1; rgbfilter = 3'b100; cur_test = 1'b1;
    start_frame();
    send_line(160, 8'h0A, 8'h90);
    end_frame("bars", 1, 80);
    cur_test = 1'b0;

    // Reset in the middle of a line aborts the frame until a full vsync cycle.
    rgbmode = 1'b1; testmode = 1'b0; rgbfilter = 3'b000; cur_exp = 12'hA5C;
    start_frame();
    send_line(4, 8'h0A, 8'h5C);
    check("pre_rst_pending", 32'(sb.size()), 32'd0);
    ov_href = 1'b1;
    send_byte(8'h0A);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_we", {31'd0, frame_we}, 32'd0);
    check("midrst_addr", 32'(frame_addr), 32'd0);
    rst = 1'b0;
    m_cap = 1'b0;
    wr_base = wr_cnt; done_base = done_cnt;
    send_byte(8'h5C);
    ov_pclk = 1'b0;
    @(negedge clk);
    ov_href = 1'b0;
    repeat (2) @(negedge clk);
    send_line(4, 8'h0A, 8'h5C);
    send_line(4, 8'h0A, 8'h5C);
    end_frame("rst_abort", 0, 0);
    start_frame();
    send_line(2, 8'h0A, 8'h5C);
    end_frame("after_rst", 1, 1);

    // Full frame with 10 extra lines: 4800 writes, nothing past 4799.
    cur_exp = 12'hA5C;
    start_frame();
    for (int r = 0; r < 130; r++) begin
      if (r % 2 == 1)  send_line(0, 8'h0A, 8'h5C);
      else if (r < 120) send_line(160, 8'h0A, 8'h5C);
      else              send_line(8, 8'h0A, 8'h5C);
    end
    end_frame("full_130", 1, 4800);
    check("full_last_addr", 32'(last_addr), 32'd4799);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 c_img_cols, 80, frame buffer columns (camera QQVGA 160 decimated by 2).
REQ-002 c_img_rows, 60, frame buffer rows (camera 120 decimated by 2).
REQ-003 c_nb_img_pxls, 13, frame address width (4800 < 2^13).
REQ-004 c_nb_buf_red / c_nb_buf_green / c_nb_buf_blue, 4 / 4 / 4, channel widths; c_nb_buf = their sum (12).
REQ-005 c_thresh, 8, 4-bit channel threshold used by the colour filter.
REQ-006 clk  in  1  system clock, the only clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 ov7670_pclk / ov7670_vsync / ov7670_href  in  1 each  camera pixel clock, frame sync (high = vertical blanking) and line valid, sampled as data.
REQ-009 ov7670_d  in  8  camera data byte.
REQ-010 rgbmode  in  1  1 = RGB444 two-byte pixels; 0 = YUYV, Y byte stored.
REQ-011 testmode  in  1  1 = colour-bar pattern replaces camera data; camera timing still used.
REQ-012 rgbfilter  in  3  {R,G,B} filter select; 000 = bypass.
REQ-013 frame_we  out  1  frame-buffer write strobe, one clk wide.
REQ-014 frame_addr  out  c_nb_img_pxls  write address, row*c_img_cols+col.
REQ-015 frame_pixel  out  c_nb_buf  write data {R,G,B}.
REQ-016 frame_done  out  1  one-clk pulse at end of a captured frame.

Function
REQ-017 pclk, vsync, href and d SHALL pass through an identical 2-flop synchroniser; a pclk rising edge is detected when stage2=1 and stage3=0; data used is stage-2 d in that cycle; clk SHALL be >= 3x pclk.
REQ-018 FSM states: WAIT_VS (wait synced vsync=1), VBLANK (wait vsync=0), ACTIVE; WAIT_VS->VBLANK on vsync=1; VBLANK->ACTIVE on vsync=0; ACTIVE->VBLANK on vsync=1.
REQ-019 Partial frames after reset SHALL NOT be written: capture occurs only in ACTIVE.
REQ-020 In ACTIVE, each pclk edge with href=1 toggles byte phase (first/second); byte phase clears when href=0.
REQ-021 Camera column counter (0..159) increments after each second byte; clears on href falling edge; camera row counter (0..119) increments on href falling edge; both clear on entering VBLANK.
REQ-022 A pixel SHALL be written only when camera row and column are both even and within 160x120; later pixels ignored.
REQ-023 frame_we SHALL assert exactly one clk after the clk in which the second byte edge is detected.
REQ-024 frame_addr SHALL start at 0 per frame, increment by 1 after each write, saturate writes at 4799 (write to 4800+ suppressed).
REQ-025 RGB data: first byte [3:0] = R, second byte [7:4] = G, [3:0] = B.
REQ-026 YUV data (rgbmode=0): frame_pixel = {4'h0, first byte}; colour filter bypassed.
REQ-027 Filter (rgbmode=1, rgbfilter!=0): pixel kept if every selected channel >= c_thresh and every unselected channel < c_thresh, else written as 0.
REQ-028 testmode=1: frame_pixel from bar table indexed by col/16 (0..4): FFF, F00, 0F0, 00F, 000; filter not applied.
REQ-029 frame_done SHALL pulse one clk when ACTIVE->VBLANK and at least one write occurred that frame.
REQ-030 rgbmode/testmode/rgbfilter SHALL be sampled once per frame on VBLANK->ACTIVE.

Reset
REQ-031 rst SHALL force state WAIT_VS, counters and byte phase to 0, frame_we=0, frame_addr=0, frame_pixel=0, frame_done=0, synchronisers to 0, sampled mode registers to 0.
REQ-032 rst mid-frame SHALL abort capture; no write until the next full vsync high-low sequence.

Structure
REQ-033 Image sizes, buffer widths, c_thresh and the test-bar colour table SHALL sit in a shared package/include used also by the display side.
REQ-034 Colour filter plus test-pattern mux SHALL be one combinational sub-module, color_proc.

Verification
REQ-035 Reset, then frame starting mid-ACTIVE (vsync low) -> no frame_we until vsync 1->0; first write frame_addr=0.
REQ-036 Full 160x120 RGB frame, pixel bytes 0x0A,0x5C -> 4800 writes, last addr 4799, frame_pixel=A5C, frame_done one pulse.
REQ-037 rgbfilter=100, pixels A00 and A90 -> A00 and 000 written.
REQ-038 rgbmode=0, first byte 0x7E -> frame_pixel=07E.
REQ-039 testmode=1 -> addresses 0,16,32,48,64 hold FFF,F00,0F0,00F,000.
REQ-040 Extra 10 lines (130 lines) -> writes stop at 4799, no address wrap.
